// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and elaboration helpers for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } sup_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One shared phase counter must reach the largest terminal value.
  function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                   input int lock_stable);
    return $clog2(max3(rst_cycles, lock_timeout, lock_stable) + 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the refclk domain.
module pll_lock_supervisor_sync_2ff (
  input  logic refclk,
  input  logic rst,
  input  logic d_in,
  output logic d_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign d_sync = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for and qualifies lock, then releases the core reset.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 742500,
  parameter int LOCK_STABLE  = 1024,
  parameter int CNT_W        = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             force_relock,
  output logic             pll_rst,
  output logic             core_rst,
  output logic             ready,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] lost_count
);

  localparam int CNT_BITS = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

  localparam logic [CNT_BITS-1:0] RST_LAST     = CNT_BITS'(RST_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_BITS-1:0] STABLE_LAST  = CNT_BITS'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]    EVT_MAX      = '1;

  logic lk;

  pll_lock_supervisor_sync_2ff u_lock_sync (
    .refclk (refclk),
    .rst    (rst),
    .d_in   (pll_locked),
    .d_sync (lk)
  );

  sup_state_e          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0]    lost_q, lost_d;
  logic                pll_rst_q, pll_rst_d;
  logic                core_rst_q, core_rst_d;
  logic                ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;

    if (force_relock) begin
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still wins.
          if (lk) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = (retry_q == EVT_MAX) ? retry_q : retry_q + CNT_W'(1);
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
        ST_STABLE: begin
          if (!lk) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
        ST_RUN: begin
          if (!lk) begin
            lost_d  = (lost_q == EVT_MAX) ? lost_q : lost_q + CNT_W'(1);
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs decode the next state so they switch on the entry edge.
    pll_rst_d  = (state_d == ST_RESET_PLL);
    ready_d    = (state_d == ST_RUN);
    core_rst_d = !ready_d;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= ST_RESET_PLL;
      cnt_q      <= '0;
      retry_q    <= '0;
      lost_q     <= '0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      lost_q     <= lost_d;
      pll_rst_q  <= pll_rst_d;
      core_rst_q <= core_rst_d;
      ready_q    <= ready_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign core_rst    = core_rst_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;
  assign lost_count  = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a per-cycle reference model.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 20;
  localparam int LOCK_STABLE  = 8;
  localparam int CNT_W        = 8;
  localparam int EVT_MAX      = (1 << CNT_W) - 1;

  localparam int PH_PULSE = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_QUAL  = 2;
  localparam int PH_RUN   = 3;

  logic             refclk = 1'b0;
  logic             rst = 1'b1;
  logic             pll_locked = 1'b0;
  logic             force_relock = 1'b0;
  logic             pll_rst;
  logic             core_rst;
  logic             ready;
  logic [CNT_W-1:0] retry_count;
  logic [CNT_W-1:0] lost_count;

  int vectors = 0;
  int miscompares = 0;

  pll_lock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_STABLE  (LOCK_STABLE),
    .CNT_W        (CNT_W)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .core_rst     (core_rst),
    .ready        (ready),
    .retry_count  (retry_count),
    .lost_count   (lost_count)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: phase plus cycles remaining in it; lock seen through a 2-deep delay line.
  int m_phase = PH_PULSE;
  int m_left = RST_CYCLES;
  int m_retry = 0;
  int m_lost = 0;
  bit m_h1 = 1'b0;
  bit m_h2 = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge refclk) begin : model_compare
    bit lk_seen;
    lk_seen = m_h2;
    if (rst) begin
      m_phase = PH_PULSE;
      m_left  = RST_CYCLES;
      m_retry = 0;
      m_lost  = 0;
      m_h1    = 1'b0;
      m_h2    = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_h2 = m_h1;
      m_h1 = pll_locked;
      if (force_relock) begin
        m_phase = PH_PULSE;
        m_left  = RST_CYCLES;
      end else if (m_phase == PH_PULSE) begin
        m_left--;
        if (m_left == 0) begin
          m_phase = PH_WAIT;
          m_left  = LOCK_TIMEOUT;
        end
      end else if (m_phase == PH_WAIT) begin
        if (lk_seen) begin
          m_phase = PH_QUAL;
          m_left  = LOCK_STABLE;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_retry = (m_retry < EVT_MAX) ? m_retry + 1 : EVT_MAX;
            m_phase = PH_PULSE;
            m_left  = RST_CYCLES;
          end
        end
      end else if (m_phase == PH_QUAL) begin
        if (!lk_seen) begin
          m_phase = PH_WAIT;
          m_left  = LOCK_TIMEOUT;
        end else begin
          m_left--;
          if (m_left == 0) m_phase = PH_RUN;
        end
      end else begin
        if (!lk_seen) begin
          m_lost  = (m_lost < EVT_MAX) ? m_lost + 1 : EVT_MAX;
          m_phase = PH_PULSE;
          m_left  = RST_CYCLES;
        end
      end
    end
    #1;
    if (m_valid) begin
      check("model_pll_rst", int'(pll_rst), int'(m_phase == PH_PULSE));
      check("model_core_rst", int'(core_rst), int'(m_phase != PH_RUN));
      check("model_ready", int'(ready), int'(m_phase == PH_RUN));
      check("model_retry_count", int'(retry_count), m_retry);
      check("model_lost_count", int'(lost_count), m_lost);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  initial begin
    // Lock present from the start.
    pll_locked = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    check("t1_pll_rst_cycle3", int'(pll_rst), 1);
    tick(1);
    check("t1_pll_rst_cycle4", int'(pll_rst), 0);
    tick(8);
    check("t1_ready_cycle12", int'(ready), 0);
    tick(1);
    check("t1_ready_cycle13", int'(ready), 1);
    check("t1_core_rst_cycle13", int'(core_rst), 0);
    check("t1_retry_zero", int'(retry_count), 0);
    check("t1_lost_zero", int'(lost_count), 0);

    // Lock loss while running.
    pll_locked = 1'b0;
    tick(2);
    check("t4_ready_still_high", int'(ready), 1);
    tick(1);
    check("t4_ready_dropped", int'(ready), 0);
    check("t4_lost_one", int'(lost_count), 1);
    check("t4_pll_rst_on", int'(pll_rst), 1);
    tick(3);
    check("t4_pll_rst_held", int'(pll_rst), 1);
    tick(1);
    check("t4_pll_rst_released", int'(pll_rst), 0);
    pll_locked = 1'b1;
    tick(10);
    check("t4_relock_not_yet", int'(ready), 0);
    tick(1);
    check("t4_relock_ready", int'(ready), 1);

    // Forced relock from RUN, then again mid pulse.
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    check("t5_force_pll_rst", int'(pll_rst), 1);
    check("t5_force_ready", int'(ready), 0);
    tick(2);
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    tick(3);
    check("t5_pulse_restarted", int'(pll_rst), 1);
    tick(1);
    check("t5_pulse_end", int'(pll_rst), 0);
    check("t5_lost_unchanged", int'(lost_count), 1);
    check("t5_retry_unchanged", int'(retry_count), 0);
    tick(8);
    check("t5_ready_not_yet", int'(ready), 0);
    tick(1);
    check("t5_ready_again", int'(ready), 1);

    // One-cycle lock glitch during qualification.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(10);
    check("t3_ready_cycle21", int'(ready), 0);
    tick(1);
    check("t3_ready_cycle22", int'(ready), 1);
    check("t3_retry_zero", int'(retry_count), 0);

    // Lock never arrives.
    pll_locked = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(24);
    check("t2_retry_1", int'(retry_count), 1);
    check("t2_pll_rst_1", int'(pll_rst), 1);
    tick(24);
    check("t2_retry_2", int'(retry_count), 2);
    tick(24);
    check("t2_retry_3", int'(retry_count), 3);
    check("t2_ready_low", int'(ready), 0);

    // Saturation, then reset in the middle of a wait window.
    tick(24 * 297);
    check("t6_retry_saturated", int'(retry_count), 255);
    tick(10);
    check("t6_in_wait", int'(pll_rst), 0);
    rst = 1'b1;
    tick(1);
    check("t6_rst_pll_rst", int'(pll_rst), 1);
    check("t6_rst_core_rst", int'(core_rst), 1);
    check("t6_rst_ready", int'(ready), 0);
    check("t6_rst_retry", int'(retry_count), 0);
    check("t6_rst_lost", int'(lost_count), 0);
    rst = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
